axi_stream_insert_header_mb: RTL and testbench
==============================================

Name: axi_stream_insert_header_mb

Overview:
AXI-Stream header inserter, successor to the single-word inserter. It prepends a header of up to HDR_BEATS data words, with a variable byte count, to every packet. The output is byte-packed: all beats are full except the last. The block sits between the packet source and the downstream AXI-Stream sink, and adds a no-header bypass mode selected per packet.

Parameters:
DATA_WD, 32, data bus width in bits (multiple of 8)
DATA_BYTE_WD, DATA_WD/8, bytes per beat (B)
HDR_BEATS, 2, max header length in data words
HDR_WD, HDR_BEATS*DATA_WD, header bus width
HDR_BYTE_WD, HDR_WD/8, header keep width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
valid_in  in  1  payload valid
data_in  in  DATA_WD  payload; byte lane B-1 (MSB) is first on wire
keep_in  in  DATA_BYTE_WD  all-ones except on last beat; last beat contiguous from MSB (e.g. 1100)
last_in  in  1  last payload beat
ready_in  out  1  payload ready
valid_out  out  1  output valid
data_out  out  DATA_WD  packed output, MSB first
keep_out  out  DATA_BYTE_WD  all-ones except last beat; last beat contiguous from MSB
last_out  out  1  last output beat
ready_out  in  1  downstream ready
valid_insert  in  1  header valid
header_insert  in  HDR_WD  header; valid bytes right-aligned (LSB side)
keep_insert  in  HDR_BYTE_WD  contiguous from LSB; H = popcount, 0 = bypass
ready_insert  out  1  header ready
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE. valid_out, last_out, busy = 0. data_out, keep_out, and the residual register = 0. Any packet in flight is dropped; there is no partial output after reset.
- Output register: it loads when !valid_out || ready_out (adv). While valid_out && !ready_out, data_out, keep_out and last_out are held stable.
- ready_insert = (state==IDLE). The header handshake latches header_insert and H, and sets r = H mod B. The first output beat becomes valid on the clock edge after the handshake.
- States:
  - IDLE -> HDR on handshake if H>=B; -> DATA if H<B. For H<B, including bypass (H=0), residual = the H header bytes.
  - HDR: emits floor(H/B) full header beats, taken from the most significant valid byte downward, one per adv. After the last of these -> DATA. Residual = the lowest r header bytes.
  - DATA: ready_in = adv. On each accepted beat, the output is {r residual bytes, top B-r bytes of data_in}, and the residual becomes the low r bytes of data_in. For r=0 the data passes straight through.
  - Last beat, with n = popcount(keep_in):
    - If r+n <= B: last_out=1, keep_out = r+n MSB ones, state -> IDLE.
    - Else: emit a full beat, residual holds r+n-B bytes, state -> FLUSH.
  - FLUSH: ready_in = 0. On adv, emit the residual with last_out=1 and keep_out = MSB ones of that count, then -> IDLE.
- Beat count: total output beats = ceil((H+payload bytes)/B).
- Header ordering: payload is never accepted before its header handshake. ready_in = 0 in IDLE, HDR and FLUSH.
- Packet spacing: at least one IDLE cycle between packets. last_out acceptance and a new header handshake cannot coincide.
- last_in with keep_in=0: treated as n=0. The residual is emitted as the last beat if r>0. If r=0, the previous output beat cannot be retro-flagged, so a 1-beat with keep_out=0 and last_out=1 is emitted.
- Non-contiguous keep_insert or keep_in: undefined; no checking.
- Mid-packet gaps: valid_in low mid-packet inserts bubbles only; no data loss.
- Outputs are registered; there is no combinational path from ready_out to ready_in other than the adv term.

Test Plan:
1. Header 0x..._FFEEDDCC, keep_insert 0x07, with data valid in the same cycle: AABBCCDD, EEFF0011, 22334455, 66778899, then 00AABBCC last keep 1100. Required output: EEDDCCAA, BBCCDDEE, FF001122, 33445566, 77889900, then AA000000 last keep 1000, via FLUSH.
2. Same packet, but valid_in asserted 2 cycles before valid_insert -> ready_in stays 0 until the header handshake; output identical to scenario 1.
3. Header 0x0102030405060708, keep_insert 0xFF; data AABBCCDD last keep 1111 -> output 01020304, 05060708, then AABBCCDD last keep 1111.
4. keep_insert 0x00 (bypass); data 11223344, 55667788 last keep 1110 -> the same two beats, each one cycle after acceptance; last keep 1110.
5. Scenario 1 with ready_out toggling 1,0,1,0 -> data_out held while stalled; 6 beats delivered in order with no loss or duplication; ready_in low on stalled cycles.
6. rst pulsed after the third output beat of scenario 1 -> valid_out=0 the next cycle and state IDLE. A following scenario-3 packet is output correctly.

Source files
------------

// File: rtl/axi_stream_insert_header_mb.sv
// AXI-Stream header inserter: prepends 0..HDR_BYTE_WD header bytes to each packet
// and re-packs the payload so that every beat except the last is full.
//   state   | meaning
//   S_IDLE  | waiting for header handshake, no packet in flight
//   S_HDR   | emitting full header beats from the left-aligned header register
//   S_DATA  | merging residual bytes with incoming payload beats
//   S_FLUSH | emitting leftover residual bytes as the final beat
module axi_stream_insert_header_mb #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int HDR_BEATS    = 2,
  parameter int HDR_WD       = HDR_BEATS * DATA_WD,
  parameter int HDR_BYTE_WD  = HDR_WD / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [HDR_WD-1:0]       header_insert,
  input  logic [HDR_BYTE_WD-1:0]  keep_insert,
  output logic                    ready_insert,
  output logic                    busy
);

  localparam int CW = $clog2(HDR_BYTE_WD + 2 * DATA_BYTE_WD + 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_FLUSH} state_t;

  state_t                  r_state, w_state_nx;
  logic [HDR_WD-1:0]       r_hdr, w_hdr_nx, w_hdr_al;
  logic [DATA_WD-1:0]      r_res, w_res_nx, w_din_m, w_dout;
  logic [CW-1:0]           r_rcnt, w_rcnt_nx, r_hcnt, w_hcnt_nx, r_fcnt, w_fcnt_nx;
  logic [CW-1:0]           w_h, w_hpad, w_n, w_sum, w_rpad;
  logic [DATA_BYTE_WD-1:0] w_kout;
  logic                    w_adv, w_hs, w_acc, w_emit, w_lout;

  function automatic logic [CW-1:0] pop_hdr(input logic [HDR_BYTE_WD-1:0] k);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < HDR_BYTE_WD; i++) c = c + CW'(k[i]);
    return c;
  endfunction

  function automatic logic [CW-1:0] pop_dat(input logic [DATA_BYTE_WD-1:0] k);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) c = c + CW'(k[i]);
    return c;
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] msb_ones(input logic [CW-1:0] cnt);
    logic [DATA_BYTE_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[DATA_BYTE_WD-1-i] = (CW'(i) < cnt);
    return m;
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  assign w_adv        = !valid_out || ready_out;
  assign ready_insert = (r_state == S_IDLE);
  assign ready_in     = (r_state == S_DATA) && w_adv;
  assign busy         = (r_state != S_IDLE);
  assign w_hs         = valid_insert && ready_insert;
  assign w_acc        = valid_in && ready_in;

  // Header bytes are left-aligned so every header beat is simply the top word.
  assign w_h      = pop_hdr(keep_insert);
  assign w_hpad   = CW'(HDR_BYTE_WD) - w_h;
  assign w_hdr_al = header_insert << {w_hpad, 3'b000};

  assign w_n     = pop_dat(keep_in);
  assign w_sum   = r_rcnt + w_n;
  assign w_rpad  = CW'(DATA_BYTE_WD) - r_rcnt;
  assign w_din_m = data_in & byte_mask(keep_in);

  always_comb begin
    w_state_nx = r_state;
    w_hdr_nx   = r_hdr;
    w_res_nx   = r_res;
    w_rcnt_nx  = r_rcnt;
    w_hcnt_nx  = r_hcnt;
    w_fcnt_nx  = r_fcnt;
    w_emit     = 1'b0;
    w_dout     = r_res;
    w_kout     = '1;
    w_lout     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_hdr_nx   = w_hdr_al;
          w_res_nx   = w_hdr_al[HDR_WD-1 -: DATA_WD];
          w_rcnt_nx  = w_h % CW'(DATA_BYTE_WD);
          w_hcnt_nx  = w_h / CW'(DATA_BYTE_WD);
          w_state_nx = (w_hcnt_nx != '0) ? S_HDR : S_DATA;
        end
      end
      S_HDR: begin
        if (w_adv) begin
          w_emit    = 1'b1;
          w_dout    = r_hdr[HDR_WD-1 -: DATA_WD];
          w_hdr_nx  = r_hdr << DATA_WD;
          w_hcnt_nx = r_hcnt - CW'(1);
          if (r_hcnt == CW'(1)) begin
            w_res_nx   = w_hdr_nx[HDR_WD-1 -: DATA_WD];
            w_state_nx = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_acc) begin
          w_emit   = 1'b1;
          w_dout   = r_res | (data_in >> {r_rcnt, 3'b000});
          w_res_nx = w_din_m << {w_rpad, 3'b000};
          if (last_in) begin
            if (w_sum <= CW'(DATA_BYTE_WD)) begin
              w_kout     = msb_ones(w_sum);
              w_lout     = 1'b1;
              w_state_nx = S_IDLE;
            end else begin
              w_fcnt_nx  = w_sum - CW'(DATA_BYTE_WD);
              w_state_nx = S_FLUSH;
            end
          end
        end
      end
      S_FLUSH: begin
        if (w_adv) begin
          w_emit     = 1'b1;
          w_dout     = r_res;
          w_kout     = msb_ones(r_fcnt);
          w_lout     = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hdr     <= '0;
      r_res     <= '0;
      r_rcnt    <= '0;
      r_hcnt    <= '0;
      r_fcnt    <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      r_hdr  <= w_hdr_nx;
      r_res  <= w_res_nx;
      r_rcnt <= w_rcnt_nx;
      r_hcnt <= w_hcnt_nx;
      r_fcnt <= w_fcnt_nx;
      if (w_adv) begin
        valid_out <= w_emit;
        last_out  <= w_emit && w_lout;
        if (w_emit) begin
          data_out <= w_dout;
          keep_out <= w_kout;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_insert_header_mb.sv
// Directed bench for axi_stream_insert_header_mb: a table of packets with
// hand-computed output beats, plus pre-valid, stall and mid-packet reset sequences.
module tb_axi_stream_insert_header_mb;
  localparam int DW = 32, BW = 4, HW = 64, HBW = 8;

  logic           clk, rst;
  logic           valid_in, last_in, ready_in;
  logic [DW-1:0]  data_in, data_out;
  logic [BW-1:0]  keep_in, keep_out;
  logic           valid_out, last_out, ready_out;
  logic           valid_insert, ready_insert, busy;
  logic [HW-1:0]  header_insert;
  logic [HBW-1:0] keep_insert;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic [HW-1:0]     hdr;
    logic [HBW-1:0]    kins;
    int                n_in;
    logic [5:0][31:0]  din;
    logic [5:0][3:0]   kin;
    int                n_out;
    logic [6:0][31:0]  dout;
    logic [6:0][3:0]   kout;
  } vec_t;

  vec_t vecs[7];

  axi_stream_insert_header_mb dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
    .valid_insert(valid_insert), .header_insert(header_insert), .keep_insert(keep_insert),
    .ready_insert(ready_insert), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] kmask(input logic [3:0] k);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  // Entered and left just after a rising edge. pre delays the header by that
  // many cycles while payload is already valid; stall toggles ready_out;
  // abort_after > 0 stops once that many output beats have been taken.
  task automatic run_vec(input vec_t v, input int pre, input bit stall, input int abort_after);
    int ii, oi, cyc;
    int acc_c[8];
    bit hdr_done, held;
    logic [31:0] hd;
    logic [3:0] hk;
    logic hl;
    ii = 0; oi = 0; cyc = 0; hdr_done = 0; held = 0; hd = '0; hk = '0; hl = 0;
    for (int i = 0; i < 8; i++) acc_c[i] = -10;
    while (cyc < 200 && oi < v.n_out && !(abort_after > 0 && oi >= abort_after)) begin
      valid_insert  = (cyc >= pre) && !hdr_done;
      header_insert = v.hdr;
      keep_insert   = v.kins;
      valid_in      = (ii < v.n_in);
      data_in       = (ii < v.n_in) ? v.din[ii] : '0;
      keep_in       = (ii < v.n_in) ? v.kin[ii] : '0;
      last_in       = (ii == v.n_in - 1);
      ready_out     = stall ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (held) begin
        chk("stall_hold_valid", {63'd0, valid_out}, 64'd1);
        chk("stall_hold_data", {32'd0, data_out}, {32'd0, hd});
        chk("stall_hold_keep", {60'd0, keep_out}, {60'd0, hk});
        chk("stall_hold_last", {63'd0, last_out}, {63'd0, hl});
      end
      held = valid_out && !ready_out;
      hd = data_out; hk = keep_out; hl = last_out;
      if (held) chk("stall_ready_in", {63'd0, ready_in}, 64'd0);
      if (!hdr_done) chk("ready_in_before_hdr", {63'd0, ready_in}, 64'd0);
      if (valid_out && ready_out) begin
        chk($sformatf("beat%0d_data", oi), {32'd0, data_out & kmask(v.kout[oi])},
            {32'd0, v.dout[oi] & kmask(v.kout[oi])});
        chk($sformatf("beat%0d_keep", oi), {60'd0, keep_out}, {60'd0, v.kout[oi]});
        chk($sformatf("beat%0d_last", oi), {63'd0, last_out}, {63'd0, oi == v.n_out - 1});
        if (v.kins == 0 && !stall && pre == 0)
          chk($sformatf("bypass_latency%0d", oi), 64'(cyc), 64'(acc_c[oi] + 1));
        oi++;
      end
      if (valid_in && ready_in) begin
        acc_c[ii] = cyc;
        ii++;
      end
      if (valid_insert && ready_insert) hdr_done = 1;
      @(posedge clk);
      #1;
      cyc++;
    end
    valid_in = 0; valid_insert = 0; last_in = 0; ready_out = 1;
    if (abort_after == 0) begin
      chk("beats_delivered", 64'(oi), 64'(v.n_out));
      @(negedge clk);
      chk("no_extra_beat", {63'd0, valid_out}, 64'd0);
      chk("idle_after_pkt", {63'd0, busy}, 64'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 7; i++) vecs[i] = '0;
    // Mixed header H=3 (residual 3), flush of one byte
    vecs[0].hdr = 64'h12345678_FFEEDDCC; vecs[0].kins = 8'h07; vecs[0].n_in = 5;
    vecs[0].din[0] = 32'hAABBCCDD; vecs[0].din[1] = 32'hEEFF0011; vecs[0].din[2] = 32'h22334455;
    vecs[0].din[3] = 32'h66778899; vecs[0].din[4] = 32'h00AABBCC;
    vecs[0].kin[0] = 4'hF; vecs[0].kin[1] = 4'hF; vecs[0].kin[2] = 4'hF; vecs[0].kin[3] = 4'hF; vecs[0].kin[4] = 4'hC;
    vecs[0].n_out = 6;
    vecs[0].dout[0] = 32'hEEDDCCAA; vecs[0].dout[1] = 32'hBBCCDDEE; vecs[0].dout[2] = 32'hFF001122;
    vecs[0].dout[3] = 32'h33445566; vecs[0].dout[4] = 32'h77889900; vecs[0].dout[5] = 32'hAA000000;
    vecs[0].kout[0] = 4'hF; vecs[0].kout[1] = 4'hF; vecs[0].kout[2] = 4'hF; vecs[0].kout[3] = 4'hF;
    vecs[0].kout[4] = 4'hF; vecs[0].kout[5] = 4'h8;
    // Full 8-byte header, single payload beat
    vecs[1].hdr = 64'h01020304_05060708; vecs[1].kins = 8'hFF; vecs[1].n_in = 1;
    vecs[1].din[0] = 32'hAABBCCDD; vecs[1].kin[0] = 4'hF;
    vecs[1].n_out = 3;
    vecs[1].dout[0] = 32'h01020304; vecs[1].dout[1] = 32'h05060708; vecs[1].dout[2] = 32'hAABBCCDD;
    vecs[1].kout[0] = 4'hF; vecs[1].kout[1] = 4'hF; vecs[1].kout[2] = 4'hF;
    // Bypass
    vecs[2].hdr = 64'hDEADBEEF_CAFEF00D; vecs[2].kins = 8'h00; vecs[2].n_in = 2;
    vecs[2].din[0] = 32'h11223344; vecs[2].din[1] = 32'h55667788; vecs[2].kin[0] = 4'hF; vecs[2].kin[1] = 4'hE;
    vecs[2].n_out = 2;
    vecs[2].dout[0] = 32'h11223344; vecs[2].dout[1] = 32'h55667788; vecs[2].kout[0] = 4'hF; vecs[2].kout[1] = 4'hE;
    // H=5: one header beat, residual 1, flush
    vecs[3].hdr = 64'h000000A1_B2C3D4E5; vecs[3].kins = 8'h1F; vecs[3].n_in = 1;
    vecs[3].din[0] = 32'h11223344; vecs[3].kin[0] = 4'hF;
    vecs[3].n_out = 3;
    vecs[3].dout[0] = 32'hA1B2C3D4; vecs[3].dout[1] = 32'hE5112233; vecs[3].dout[2] = 32'h44000000;
    vecs[3].kout[0] = 4'hF; vecs[3].kout[1] = 4'hF; vecs[3].kout[2] = 4'h8;
    // H=4, last beat keep=0 with r=0 -> empty last beat
    vecs[4].hdr = 64'h00000000_0A0B0C0D; vecs[4].kins = 8'h0F; vecs[4].n_in = 2;
    vecs[4].din[0] = 32'h11223344; vecs[4].din[1] = 32'h99999999; vecs[4].kin[0] = 4'hF; vecs[4].kin[1] = 4'h0;
    vecs[4].n_out = 3;
    vecs[4].dout[0] = 32'h0A0B0C0D; vecs[4].dout[1] = 32'h11223344; vecs[4].dout[2] = 32'h00000000;
    vecs[4].kout[0] = 4'hF; vecs[4].kout[1] = 4'hF; vecs[4].kout[2] = 4'h0;
    // H=2, last beat keep=0 with r=2 -> residual is the last beat
    vecs[5].hdr = 64'h00000000_0000BEEF; vecs[5].kins = 8'h03; vecs[5].n_in = 2;
    vecs[5].din[0] = 32'h11223344; vecs[5].din[1] = 32'h55555555; vecs[5].kin[0] = 4'hF; vecs[5].kin[1] = 4'h0;
    vecs[5].n_out = 2;
    vecs[5].dout[0] = 32'hBEEF1122; vecs[5].dout[1] = 32'h33440000; vecs[5].kout[0] = 4'hF; vecs[5].kout[1] = 4'hC;
    // H=1, r+n exactly B -> no flush
    vecs[6].hdr = 64'h00000000_00000077; vecs[6].kins = 8'h01; vecs[6].n_in = 1;
    vecs[6].din[0] = 32'h11223344; vecs[6].kin[0] = 4'hE;
    vecs[6].n_out = 1;
    vecs[6].dout[0] = 32'h77112233; vecs[6].kout[0] = 4'hF;

    rst = 1; valid_in = 0; data_in = '0; keep_in = '0; last_in = 0; ready_out = 1;
    valid_insert = 0; header_insert = '0; keep_insert = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst_valid_out", {63'd0, valid_out}, 64'd0);
    chk("rst_last_out", {63'd0, last_out}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_data_out", {32'd0, data_out}, 64'd0);
    chk("rst_keep_out", {60'd0, keep_out}, 64'd0);
    chk("rst_ready_insert", {63'd0, ready_insert}, 64'd1);
    chk("rst_ready_in", {63'd0, ready_in}, 64'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], 0, 1'b0, 0);

    run_vec(vecs[0], 2, 1'b0, 0);
    run_vec(vecs[0], 0, 1'b1, 0);

    run_vec(vecs[0], 0, 1'b0, 3);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("midrst_valid_out", {63'd0, valid_out}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_ready_insert", {63'd0, ready_insert}, 64'd1);
    chk("midrst_last_out", {63'd0, last_out}, 64'd0);
    chk("midrst_data_out", {32'd0, data_out}, 64'd0);
    @(posedge clk);
    #1;
    run_vec(vecs[1], 0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
